// File: rtl/rr_requester_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_requester_bank_if
// Description : Bundles the job, drain, request/grant and completion signals
//               of the round-robin requester bank. The master modport is the
//               bank itself; the slave modport is its environment (job
//               source, drain control and the arbiter).
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_requester_bank_if #(
  parameter int N  = 4,
  parameter int CW = 3,
  parameter int IW = 2
);
  logic             job_valid_i;
  logic [IW-1:0]    job_ch_i;
  logic             job_ready_o;
  logic             drain_i;
  logic             drained_o;
  logic [N-1:0]     req_o;
  logic [N-1:0]     gnt_i;
  logic             done_valid_o;
  logic [IW-1:0]    done_ch_o;
  logic [CW+IW-1:0] pending_total_o;
  logic             proto_err_o;
  logic             starve_err_o;

  modport master (
    input  job_valid_i, job_ch_i, drain_i, gnt_i,
    output job_ready_o, drained_o, req_o, done_valid_o, done_ch_o,
           pending_total_o, proto_err_o, starve_err_o
  );

  modport slave (
    output job_valid_i, job_ch_i, drain_i, gnt_i,
    input  job_ready_o, drained_o, req_o, done_valid_o, done_ch_o,
           pending_total_o, proto_err_o, starve_err_o
  );
endinterface
`default_nettype wire

// File: rtl/rr_requester_bank.sv
`default_nettype none
// ============================================================================
// Module      : rr_requester_bank
// Description : Requester-side partner of a 4-client round-robin arbiter.
//               Keeps a saturating pending-job counter per client, raises a
//               request while a client has work, retires one job per legal
//               grant with a registered completion pulse, supports a drain
//               mode and flags arbiter protocol violations.
//               Optional starvation checker: define RR_REQ_STARVE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_requester_bank #(
  parameter int N     = 4,
  parameter int DEPTH = 7,
  parameter int CW    = 3,
  parameter int IW    = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  rr_requester_bank_if.master bus
);

  localparam int            TW         = CW + IW;
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(DEPTH);
  localparam logic [N-1:0]  C_VEC_ONE  = N'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt     [N];
  logic [CW-1:0]   w_cnt_nxt [N];
  logic [N-1:0]    w_req;
  logic [N-1:0]    w_inc;
  logic [N-1:0]    w_dec;
  logic            w_gnt_multi;
  logic            w_gnt_bad;
  logic            w_gnt_legal;
  logic            w_retire;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_ready;
  logic            w_enq;
  logic            w_all_zero;
  logic [TW-1:0]   w_total_nxt;
  logic            r_done_valid;
  logic [IW-1:0]   r_done_ch;
  logic [TW-1:0]   r_total;
  logic            r_proto_err;

  // Request per client comes straight from its counter, never from the grant.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < N; i++) begin
      w_req[i] = (r_cnt[i] != '0);
    end
  end

  assign w_all_zero  = (w_req == '0);

  // Grant legality: zero or one-hot, and only onto a requesting client.
  assign w_gnt_multi = ((bus.gnt_i & (bus.gnt_i - C_VEC_ONE)) != '0);
  assign w_gnt_bad   = ((bus.gnt_i & ~w_req) != '0);
  assign w_gnt_legal = !w_gnt_multi && !w_gnt_bad;
  assign w_retire    = w_gnt_legal && (bus.gnt_i != '0);

  // Encode the granted client index (meaningful only when w_retire is high).
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt_i[i]) begin
        w_gnt_idx = IW'(i);
      end
    end
  end

  // Enqueue acceptance uses pre-update counters, so a full client stays
  // blocked even when it is being granted in the same cycle.
  assign w_ready = (r_state == ST_RUN) && (r_cnt[bus.job_ch_i] != C_CNT_FULL);
  assign w_enq   = bus.job_valid_i && w_ready;

  // Per-client increment/decrement requests.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < N; i++) begin
      w_inc[i] = w_enq && (bus.job_ch_i == IW'(i));
      w_dec[i] = w_retire && bus.gnt_i[i];
    end
  end

  // Next counter values; enqueue and retire on the same client cancel out.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i] && (r_cnt[i] != C_CNT_FULL)) begin
        w_cnt_nxt[i] = r_cnt[i] + C_CNT_ONE;
      end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
        w_cnt_nxt[i] = r_cnt[i] - C_CNT_ONE;
      end
    end
  end

  // Total of the post-update counters, registered for pending_total_o.
  always_comb begin
    w_total_nxt = '0;
    for (int i = 0; i < N; i++) begin
      w_total_nxt = w_total_nxt + TW'(w_cnt_nxt[i]);
    end
  end

  // Drain FSM next state: RUN -> DRAIN -> DONE, drain release returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.drain_i) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.drain_i) begin
          w_state_nxt = ST_RUN;
        end else if (w_all_zero) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.drain_i) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter bank, completion pulse, running total and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
      r_done_valid <= 1'b0;
      r_done_ch    <= '0;
      r_total      <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_done_valid <= w_retire;
      if (w_retire) begin
        r_done_ch <= w_gnt_idx;
      end
      r_total <= w_total_nxt;
      if ((bus.gnt_i != '0) && !w_gnt_legal) begin
        r_proto_err <= 1'b1;
      end
    end
  end

`ifdef RR_REQ_STARVE_CHECK_EN
  logic [CW-1:0] r_wait [N];
  logic [N-1:0]  w_starve_hit;
  logic          r_starve_err;

  // A waiting client trips the check when one more foreign grant would push
  // its wait count beyond N-1.
  always_comb begin
    w_starve_hit = '0;
    for (int i = 0; i < N; i++) begin
      w_starve_hit[i] = w_retire && !bus.gnt_i[i] && w_req[i] &&
                        (r_wait[i] >= CW'(N - 1));
    end
  end

  // Wait counters: clear when idle or served, count foreign grants otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_wait[i] <= '0;
      end
      r_starve_err <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_req[i] || (w_retire && bus.gnt_i[i])) begin
          r_wait[i] <= '0;
        end else if (w_retire && (r_wait[i] != '1)) begin
          r_wait[i] <= r_wait[i] + C_CNT_ONE;
        end
      end
      if (w_starve_hit != '0) begin
        r_starve_err <= 1'b1;
      end
    end
  end

  assign bus.starve_err_o = r_starve_err;
`else
  assign bus.starve_err_o = 1'b0;
`endif

  assign bus.req_o           = w_req;
  assign bus.job_ready_o     = w_ready;
  assign bus.drained_o       = (r_state == ST_DONE);
  assign bus.done_valid_o    = r_done_valid;
  assign bus.done_ch_o       = r_done_ch;
  assign bus.pending_total_o = r_total;
  assign bus.proto_err_o     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_rr_requester_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_requester_bank
// Description : Self-checking bench for rr_requester_bank: directed vector
//               table, hand-written corner sequences and randomized traffic
//               against an integer-level model of pending jobs per client.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_requester_bank;
  localparam int N = 4, DEPTH = 7, CW = 3, IW = 2;
`ifdef RR_REQ_STARVE_CHECK_EN
  localparam bit C_STARVE = 1'b1;
`else
  localparam bit C_STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_requester_bank_if #(.N(N), .CW(CW), .IW(IW)) bus ();

  rr_requester_bank #(.N(N), .DEPTH(DEPTH), .CW(CW), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: jobs pending per client, drain phase (0 run, 1 drain, 2 done).
  int     m_cnt  [N];
  int     m_wait [N];
  int     m_state;
  bit     m_dv;
  int     m_dch;
  bit     m_perr;
  bit     m_serr;
  int     rr_ptr;

  logic [N-1:0] obs_req;
  logic         obs_rdy;
  logic         obs_drained;

  typedef struct {
    logic          jv;
    logic [IW-1:0] ch;
    logic [N-1:0]  g;
    logic [N-1:0]  ereq;
    logic          erdy;
    logic          edv;
    logic [IW-1:0] edch;
    logic [4:0]    etot;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = (m_cnt[i] > 0);
    return r;
  endfunction

  function automatic int m_total();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic bit m_ready(input int ch);
    return (m_state == 0) && (m_cnt[ch] < DEPTH);
  endfunction

  task automatic check_regs();
    chk("done_valid_o", bus.done_valid_o, m_dv);
    if (m_dv) chk("done_ch_o", bus.done_ch_o, m_dch);
    chk("pending_total_o", bus.pending_total_o, m_total());
    chk("proto_err_o", bus.proto_err_o, m_perr);
    chk("starve_err_o", bus.starve_err_o, m_serr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.job_valid_i = 1'b0;
    bus.job_ch_i    = '0;
    bus.drain_i     = 1'b0;
    bus.gnt_i       = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_wait[i] = 0;
    end
    m_state = 0; m_dv = 0; m_dch = 0; m_perr = 0; m_serr = 0; rr_ptr = 0;
    chk("rst req_o", bus.req_o, 0);
    chk("rst drained_o", bus.drained_o, 0);
    chk("rst done_ch_o", bus.done_ch_o, 0);
    check_regs();
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model,
  // then check registered outputs after the edge.
  task automatic step(input logic jv, input logic [IW-1:0] ch, input logic dr,
                      input logic [N-1:0] g);
    logic [N-1:0] req;
    int           pre_total, k;
    bit           legal, retire, acc;
    bus.job_valid_i = jv;
    bus.job_ch_i    = ch;
    bus.drain_i     = dr;
    bus.gnt_i       = g;
    #1;
    obs_req = bus.req_o; obs_rdy = bus.job_ready_o; obs_drained = bus.drained_o;
    req = m_req();
    chk("req_o", obs_req, req);
    chk("job_ready_o", obs_rdy, m_ready(int'(ch)));
    chk("drained_o", obs_drained, m_state == 2);
    pre_total = m_total();
    legal  = ($countones(g) <= 1) && ((g & ~req) == '0);
    retire = legal && (g != '0);
    k = 0;
    for (int i = 0; i < N; i++) if (g[i]) k = i;
    acc = jv && m_ready(int'(ch));
    if ((g != '0) && !legal) m_perr = 1;
`ifdef RR_REQ_STARVE_CHECK_EN
    for (int i = 0; i < N; i++) begin
      if (retire && k != i && req[i]) begin
        m_wait[i]++;
        if (m_wait[i] > N - 1) m_serr = 1;
      end else if (!req[i] || (retire && k == i)) begin
        m_wait[i] = 0;
      end
    end
`endif
    if (retire) m_cnt[k]--;
    if (acc) m_cnt[ch]++;
    m_dv = retire;
    if (retire) m_dch = k;
    case (m_state)
      0: if (dr) m_state = 1;
      1: if (!dr) m_state = 0; else if (pre_total == 0) m_state = 2;
      default: if (!dr) m_state = 0;
    endcase
    @(posedge clk); #1;
    check_regs();
  endtask

  function automatic logic [N-1:0] rr_grant();
    logic [N-1:0] req, g;
    int idx;
    req = m_req();
    g = '0;
    for (int off = 0; off < N; off++) begin
      idx = (rr_ptr + off) % N;
      if (req[idx] && g == '0) begin
        g[idx] = 1'b1;
        rr_ptr = (idx + 1) % N;
      end
    end
    return g;
  endfunction

  initial begin
    int           got [$];
    bit           drained_seen;
    logic         dr, jv;
    logic [IW-1:0] ch;
    logic [N-1:0] g, req;
    int           p, st;

    //         jv    ch    g      ereq   erdy  edv   edch  etot
    tbl[0]  = '{1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 5'd1};
    tbl[1]  = '{1'b1, 2'd0, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0, 5'd2};
    tbl[2]  = '{1'b1, 2'd0, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0, 5'd3};
    tbl[3]  = '{1'b0, 2'd0, 4'h1, 4'h1, 1'b1, 1'b1, 2'd0, 5'd2};
    tbl[4]  = '{1'b0, 2'd0, 4'h1, 4'h1, 1'b1, 1'b1, 2'd0, 5'd1};
    tbl[5]  = '{1'b0, 2'd0, 4'h1, 4'h1, 1'b1, 1'b1, 2'd0, 5'd0};
    tbl[6]  = '{1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 5'd0};
    tbl[7]  = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 5'd1};
    tbl[8]  = '{1'b1, 2'd1, 4'h0, 4'h2, 1'b1, 1'b0, 2'd0, 5'd2};
    tbl[9]  = '{1'b1, 2'd1, 4'h2, 4'h2, 1'b1, 1'b1, 2'd1, 5'd2};
    tbl[10] = '{1'b0, 2'd1, 4'h0, 4'h2, 1'b1, 1'b0, 2'd0, 5'd2};

    reset = 1'b1;
    do_reset();

    // Directed table: ch0 fill and retire, then enqueue+grant on ch1.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].jv, tbl[i].ch, 1'b0, tbl[i].g);
      chk("tbl req_o", obs_req, tbl[i].ereq);
      chk("tbl job_ready_o", obs_rdy, tbl[i].erdy);
      chk("tbl done_valid_o", bus.done_valid_o, tbl[i].edv);
      if (tbl[i].edv) chk("tbl done_ch_o", bus.done_ch_o, tbl[i].edch);
      chk("tbl pending_total_o", bus.pending_total_o, tbl[i].etot);
    end

    // Saturation on ch2, then grant while offering to the full client.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd2, 1'b0, 4'h0);
    step(1'b1, 2'd2, 1'b0, 4'h0);
    chk("full ready", obs_rdy, 0);
    chk("full total", bus.pending_total_o, 7);
    step(1'b1, 2'd2, 1'b0, 4'b0100);
    chk("full+gnt ready", obs_rdy, 0);
    chk("full+gnt total", bus.pending_total_o, 6);
    chk("full+gnt done", bus.done_valid_o, 1);

    // Protocol violations: multi-hot grant, then grant to an idle client.
    do_reset();
    step(1'b1, 2'd0, 1'b0, 4'h0);
    step(1'b1, 2'd1, 1'b0, 4'h0);
    step(1'b0, 2'd0, 1'b0, 4'b0011);
    chk("multihot proto_err", bus.proto_err_o, 1);
    chk("multihot done", bus.done_valid_o, 0);
    chk("multihot total", bus.pending_total_o, 2);
    step(1'b0, 2'd0, 1'b0, 4'h0);
    chk("proto_err sticky", bus.proto_err_o, 1);
    do_reset();
    step(1'b1, 2'd0, 1'b0, 4'h0);
    step(1'b1, 2'd1, 1'b0, 4'h0);
    step(1'b0, 2'd0, 1'b0, 4'b0100);
    chk("idle gnt proto_err", bus.proto_err_o, 1);
    chk("idle gnt done", bus.done_valid_o, 0);
    chk("idle gnt total", bus.pending_total_o, 2);

    // Drain with a round-robin arbiter: 8 retirements in order 0..3,0..3.
    do_reset();
    for (int c = 0; c < N; c++) begin
      step(1'b1, IW'(c), 1'b0, 4'h0);
      step(1'b1, IW'(c), 1'b0, 4'h0);
    end
    drained_seen = 0;
    for (int cyc = 0; cyc < 30 && !drained_seen; cyc++) begin
      g = rr_grant();
      step(1'b0, 2'd0, 1'b1, g);
      if (cyc > 0) chk("drain job_ready_o", obs_rdy, 0);
      if (bus.done_valid_o) got.push_back(int'(bus.done_ch_o));
      if (bus.drained_o) drained_seen = 1;
    end
    chk("drain done count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("drain order", got[i], i % N);
    chk("drained_o reached", drained_seen, 1);
    chk("drain starve_err_o", bus.starve_err_o, 0);
    step(1'b0, 2'd0, 1'b0, 4'h0);

    // Starvation: ch3 waits while ch0 is granted four times.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b0, 4'h0);
    step(1'b1, 2'd3, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 4'b0001);
    chk("starve after 3", bus.starve_err_o, 0);
    step(1'b0, 2'd0, 1'b0, 4'b0001);
    chk("starve after 4", bus.starve_err_o, C_STARVE);
    step(1'b1, 2'd1, 1'b0, 4'h0);
    // Mid-sequence reset discards pending jobs; no completion follows.
    do_reset();
    step(1'b0, 2'd0, 1'b0, 4'h0);
    chk("post-reset done", bus.done_valid_o, 0);

    // Randomized traffic against the model.
    dr = 1'b0;
    for (int n = 0; n < 600; n++) begin
      p = $urandom_range(0, 99);
      if (p < 2) begin
        do_reset();
        dr = 1'b0;
      end else begin
        jv = 1'($urandom_range(0, 1));
        ch = IW'($urandom_range(0, N - 1));
        if ($urandom_range(0, 19) == 0) dr = ~dr;
        req = m_req();
        g = '0;
        p = $urandom_range(0, 99);
        if (p < 60 && req != '0) begin
          st = $urandom_range(0, N - 1);
          for (int off = 0; off < N; off++)
            if (g == '0 && req[(st + off) % N]) g[(st + off) % N] = 1'b1;
        end else if (p < 63) begin
          g = N'($urandom_range(1, (1 << N) - 1));
        end
        step(jv, ch, dr, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rr_requester_bank.md
Name: rr_requester_bank

Overview:
- Requester-side counterpart to the 4-client round-robin arbiter.
- Holds a queue of pending jobs per client, drives `req_o` to the arbiter, and consumes `gnt_i` to retire one job per grant.
- Reports each completion and flags arbiter protocol violations.
- Serves as the traffic-source front end in the arbitration subsystem, and as a self-checking partner for the arbiter in benches.

Parameters:
- N, 4, number of clients; width of `req_o` and `gnt_i`.
- DEPTH, 7, maximum pending jobs per client (counter saturation value).
- CW, 3, per-client counter width; must satisfy 2^CW-1 >= DEPTH.
- IW, 2, client index width, equal to clog2(N).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- job_valid_i  input  1  enqueue one job for client `job_ch_i`
- job_ch_i  input  IW  target client of the enqueue
- job_ready_o  output  1  enqueue accepted this cycle when high together with `job_valid_i`
- drain_i  input  1  level; stop accepting jobs and flush all pending jobs
- drained_o  output  1  drain complete: `drain_i` high and all counters zero
- req_o  output  N  request vector to the arbiter
- gnt_i  input  N  grant vector from the arbiter; valid in the same cycle as `req_o`
- done_valid_o  output  1  one job retired (registered)
- done_ch_o  output  IW  client index of the retired job
- pending_total_o  output  CW+IW  sum of all per-client counters
- proto_err_o  output  1  sticky arbiter protocol violation
- starve_err_o  output  1  sticky starvation violation (see Optional Feature)

Behaviour:
- Reset: all counters 0, FSM in RUN, and all of the following are 0: `req_o`, `done_valid_o`, `done_ch_o`, `proto_err_o`, `starve_err_o`, `drained_o`, `pending_total_o`. Reset mid-operation discards all pending jobs with no done pulses.
- `req_o[i]` is registered-state-driven combinational: `req_o[i] = (cnt[i] != 0)`. It never depends on `gnt_i`, so no combinational loop exists with the arbiter.
- A grant is legal when `gnt_i` is zero or one-hot, and the granted bit's `req_o` is 1.
- Legal grant to client i:
  - At the clock edge, `cnt[i]` decrements.
  - On the next cycle, `done_valid_o` = 1 and `done_ch_o` = i (1-cycle latency).
- Illegal grant (multi-hot, or any `gnt_i[i]` with `req_o[i]` = 0):
  - No counter changes.
  - `done_valid_o` = 0 next cycle.
  - `proto_err_o` is set and holds until reset.
- Enqueue:
  - `job_ready_o = (state == RUN) && (cnt[job_ch_i] != DEPTH)`, computed from pre-update counter values.
  - An accepted job increments `cnt[job_ch_i]` at the edge.
  - A job offered while `job_ready_o` = 0 is dropped; the requester must hold it.
- Simultaneous accepted enqueue and legal grant on the same client leaves the counter unchanged, and `done_valid_o` still pulses.
- At full (`cnt` = DEPTH), `job_ready_o` = 0 even if the same client is being granted this cycle.
- Counters never wrap: no increment at DEPTH, no decrement at 0.
- `pending_total_o` is registered, updated every cycle from the post-update counter values.
- FSM states:
  - RUN: enqueue allowed; `drain_i` = 1 moves to DRAIN.
  - DRAIN: `job_ready_o` = 0; grants keep retiring jobs. When all counters are 0, move to DONE.
  - DONE: `drained_o` = 1. `drain_i` = 0 returns to RUN.
  - Any state: `drain_i` deasserted in DRAIN returns to RUN; remaining jobs stay pending.

Optional Feature:
- Macro: RR_REQ_STARVE_CHECK_EN.
- Compiled in:
  - Per-client wait counter w[i] (width CW) clears when client i receives a legal grant or when `req_o[i]` = 0.
  - w[i] increments on each legal grant to another client while `req_o[i]` = 1.
  - If w[i] would exceed N-1, `starve_err_o` is set sticky until reset.
- Compiled out: `starve_err_o` is tied to 0, no wait counters exist, and all other behaviour is identical.

Test Plan:
- Reset, then enqueue ch0 x3; tie `gnt_i` = `req_o` & 4'b0001 → `req_o` = 0001 for 3 cycles; `done_valid_o` pulses 3 times with `done_ch_o` = 0; `pending_total_o` steps 3→2→1→0.
- Enqueue 7 jobs to ch2 with no grants → `job_ready_o` = 0 on the 8th attempt, `cnt` stays 7; then grant ch2 while offering a job to ch2 → job rejected, `cnt` = 6.
- With `cnt[1]` = 2, apply an accepted enqueue to ch1 and `gnt_i` = 0010 in the same cycle → `cnt[1]` stays 2, `done_valid_o` = 1 with `done_ch_o` = 1.
- With `req_o` = 0011, drive `gnt_i` = 0011, then in a separate run `gnt_i` = 0100 → `proto_err_o` = 1 and stays high; counters unchanged; no done pulse.
- Load 2 jobs on each client, assert `drain_i`, connect the round-robin arbiter → `job_ready_o` = 0; 8 done pulses in round-robin order 0,1,2,3,0,1,2,3; `drained_o` = 1; `starve_err_o` = 0.
- With RR_REQ_STARVE_CHECK_EN: `req_o` = 1001, grant ch0 four consecutive times → `starve_err_o` = 1 after the 4th grant. Assert reset mid-sequence → all outputs return to 0 on the next edge.
